watch_time_editor: RTL and testbench

Edit-and-commit controller for the watch time counter. It tracks the cursor produced by the watch control unit and keeps a shadow copy of hour and minute while the user edits. Up/down pulses change the digit under the cursor, with legal-range wrap per digit. On exit from setting mode it issues a one-cycle load to the time counter. It also arbitrates a UART remote-set request against local editing, so the counter has exactly one load source.

---
 rtl/watch_time_editor.sv | 198 +++++++++++++++++++
 tb/tb_watch_time_editor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_editor.sv
// Watch time edit-and-commit controller: shadow BCD editing, commit load strobe, UART remote-set arbitration.
// Optional WATCH_EDIT_SKIP_UNCHANGED_EN: leaving EDIT without any digit change skips the load.
module watch_time_editor (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] i_cursor,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic [4:0] i_hour,
   input  logic [5:0] i_min,
   input  logic       i_uart_valid,
   input  logic [4:0] i_uart_hour,
   input  logic [5:0] i_uart_min,
   output logic       o_uart_ready,
   output logic       o_uart_err,
   output logic [4:0] o_edit_hour,
   output logic [5:0] o_edit_min,
   output logic       o_editing,
   output logic       o_load,
   output logic [4:0] o_load_hour,
   output logic [5:0] o_load_min
);

   // state | meaning
   // IDLE  | tracking live time, UART requests accepted
   // EDIT  | user edits shadow digits under the cursor
   // LOAD  | one-cycle load strobe to the time counter
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EDIT = 2'd1;
   localparam logic [1:0] LOAD = 2'd2;

   logic [1:0] state;
   logic [1:0] ht;
   logic [3:0] ho;
   logic [2:0] mt;
   logic [3:0] mo;
   logic [1:0] ht_n;
   logic [3:0] ho_n;
   logic [2:0] mt_n;
   logic [3:0] mo_n;
   logic [3:0] ho_max;
   logic [1:0] cap_ht;
   logic [3:0] cap_ho;
   logic [2:0] cap_mt;
   logic [3:0] cap_mo;
   logic [2:0] cur;
   logic       step_up;
   logic       step_dn;
   logic       uart_ok;
`ifdef WATCH_EDIT_SKIP_UNCHANGED_EN
   logic       dirty;
   logic       changed;
`endif

   assign cur     = (i_cursor > 3'd4) ? 3'd0 : i_cursor;
   assign step_up = i_btn_up & ~i_btn_down;
   assign step_dn = i_btn_down & ~i_btn_up;
   assign uart_ok = (i_uart_hour <= 5'd23) && (i_uart_min <= 6'd59);

   assign o_uart_ready = (state == IDLE) && (cur == 3'd0);
   assign o_editing    = (state == EDIT);
   assign o_load       = (state == LOAD);
   assign o_edit_hour  = ({3'd0, ht} * 5'd10) + {1'b0, ho};
   assign o_edit_min   = ({3'd0, mt} * 6'd10) + {2'b0, mo};

   // Binary to BCD for capture; ones digit is low nibble minus (tens*10 mod 16).
   always_comb begin
      cap_ht = 2'd0;
      cap_ho = i_hour[3:0];
      if (i_hour >= 5'd20) begin
         cap_ht = 2'd2;
         cap_ho = i_hour[3:0] - 4'd4;
      end else if (i_hour >= 5'd10) begin
         cap_ht = 2'd1;
         cap_ho = i_hour[3:0] - 4'd10;
      end
      cap_mt = 3'd0;
      cap_mo = i_min[3:0];
      if (i_min >= 6'd50) begin
         cap_mt = 3'd5;
         cap_mo = i_min[3:0] - 4'd2;
      end else if (i_min >= 6'd40) begin
         cap_mt = 3'd4;
         cap_mo = i_min[3:0] - 4'd8;
      end else if (i_min >= 6'd30) begin
         cap_mt = 3'd3;
         cap_mo = i_min[3:0] - 4'd14;
      end else if (i_min >= 6'd20) begin
         cap_mt = 3'd2;
         cap_mo = i_min[3:0] - 4'd4;
      end else if (i_min >= 6'd10) begin
         cap_mt = 3'd1;
         cap_mo = i_min[3:0] - 4'd10;
      end
   end

   always_comb begin
      ht_n   = ht;
      ho_n   = ho;
      mt_n   = mt;
      mo_n   = mo;
      ho_max = (ht == 2'd2) ? 4'd3 : 4'd9;
      if (step_up || step_dn) begin
         case (cur)
            3'd1: begin
               if (step_up) ht_n = (ht >= 2'd2) ? 2'd0 : ht + 2'd1;
               else         ht_n = (ht == 2'd0) ? 2'd2 : ht - 2'd1;
               if ((ht_n == 2'd2) && (ho > 4'd3)) ho_n = 4'd3;
            end
            3'd2: begin
               if (step_up) ho_n = (ho >= ho_max) ? 4'd0 : ho + 4'd1;
               else         ho_n = (ho == 4'd0) ? ho_max : ho - 4'd1;
            end
            3'd3: begin
               if (step_up) mt_n = (mt >= 3'd5) ? 3'd0 : mt + 3'd1;
               else         mt_n = (mt == 3'd0) ? 3'd5 : mt - 3'd1;
            end
            3'd4: begin
               if (step_up) mo_n = (mo >= 4'd9) ? 4'd0 : mo + 4'd1;
               else         mo_n = (mo == 4'd0) ? 4'd9 : mo - 4'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef WATCH_EDIT_SKIP_UNCHANGED_EN
   assign changed = {ht_n, ho_n, mt_n, mo_n} != {ht, ho, mt, mo};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         ht          <= 2'd0;
         ho          <= 4'd0;
         mt          <= 3'd0;
         mo          <= 4'd0;
         o_uart_err  <= 1'b0;
         o_load_hour <= 5'd0;
         o_load_min  <= 6'd0;
`ifdef WATCH_EDIT_SKIP_UNCHANGED_EN
         dirty       <= 1'b0;
`endif
      end else begin
         o_uart_err <= 1'b0;
         case (state)
            IDLE: begin
               if (cur != 3'd0) begin
                  ht    <= cap_ht;
                  ho    <= cap_ho;
                  mt    <= cap_mt;
                  mo    <= cap_mo;
                  state <= EDIT;
`ifdef WATCH_EDIT_SKIP_UNCHANGED_EN
                  dirty <= 1'b0;
`endif
               end else if (i_uart_valid) begin
                  if (uart_ok) begin
                     o_load_hour <= i_uart_hour;
                     o_load_min  <= i_uart_min;
                     state       <= LOAD;
                  end else begin
                     o_uart_err <= 1'b1;
                  end
               end
            end
            EDIT: begin
               if (cur == 3'd0) begin
`ifdef WATCH_EDIT_SKIP_UNCHANGED_EN
                  if (dirty) begin
                     o_load_hour <= o_edit_hour;
                     o_load_min  <= o_edit_min;
                     state       <= LOAD;
                  end else begin
                     state <= IDLE;
                  end
`else
                  o_load_hour <= o_edit_hour;
                  o_load_min  <= o_edit_min;
                  state       <= LOAD;
`endif
               end else begin
                  ht <= ht_n;
                  ho <= ho_n;
                  mt <= mt_n;
                  mo <= mo_n;
`ifdef WATCH_EDIT_SKIP_UNCHANGED_EN
                  dirty <= dirty | changed;
`endif
               end
            end
            LOAD:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_watch_time_editor.sv
// Bench for watch_time_editor: table-driven edit vectors, hand-written UART/reset sequences, load scoreboard.
module tb_watch_time_editor;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] i_cursor;
   logic       i_btn_up;
   logic       i_btn_down;
   logic [4:0] i_hour;
   logic [5:0] i_min;
   logic       i_uart_valid;
   logic [4:0] i_uart_hour;
   logic [5:0] i_uart_min;
   logic       o_uart_ready;
   logic       o_uart_err;
   logic [4:0] o_edit_hour;
   logic [5:0] o_edit_min;
   logic       o_editing;
   logic       o_load;
   logic [4:0] o_load_hour;
   logic [5:0] o_load_min;

   watch_time_editor dut (
      .clk          (clk),
      .reset        (reset),
      .i_cursor     (i_cursor),
      .i_btn_up     (i_btn_up),
      .i_btn_down   (i_btn_down),
      .i_hour       (i_hour),
      .i_min        (i_min),
      .i_uart_valid (i_uart_valid),
      .i_uart_hour  (i_uart_hour),
      .i_uart_min   (i_uart_min),
      .o_uart_ready (o_uart_ready),
      .o_uart_err   (o_uart_err),
      .o_edit_hour  (o_edit_hour),
      .o_edit_min   (o_edit_min),
      .o_editing    (o_editing),
      .o_load       (o_load),
      .o_load_hour  (o_load_hour),
      .o_load_min   (o_load_min)
   );

   always #5 clk = ~clk;

   typedef struct {
      int h;
      int m;
      int c;
   } load_t;

   typedef struct {
      int cur;
      int up;
      int dn;
      int lh;
      int lm;
      int eh;
      int em;
      int ed;
      int commit;
   } vec_t;

   load_t sb[$];
   vec_t  vt[$];
   int    cyc = 0;
   int    n_vec = 0;
   int    n_bad = 0;
   int    n_err_seen = 0;
   int    n_err_exp = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic add(input int cur, input int up, input int dn, input int lh, input int lm,
                      input int eh, input int em, input int ed, input int commit);
      vec_t v;
      v = '{cur, up, dn, lh, lm, eh, em, ed, commit};
      vt.push_back(v);
   endtask

   task automatic push_load(input int h, input int m);
      load_t e;
      e = '{h, m, cyc + 1};
      sb.push_back(e);
   endtask

   // Every load strobe must match the oldest expected load, on the expected cycle.
   always @(negedge clk) begin
      load_t e;
      if (o_uart_err) n_err_seen++;
      if (o_load) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_load: o_load=1 with %0d:%0d, none expected (cycle %0d)",
                     o_load_hour, o_load_min, cyc);
         end else begin
            e = sb.pop_front();
            check("load_hour", int'(o_load_hour), e.h);
            check("load_min", int'(o_load_min), e.m);
            check("load_cycle", cyc, e.c);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      i_cursor     = 3'd0;
      i_btn_up     = 1'b0;
      i_btn_down   = 1'b0;
      i_hour       = 5'd0;
      i_min        = 6'd0;
      i_uart_valid = 1'b0;
      i_uart_hour  = 5'd0;
      i_uart_min   = 6'd0;
      repeat (2) @(negedge clk);
      check("rst_edit_hour", int'(o_edit_hour), 0);
      check("rst_edit_min", int'(o_edit_min), 0);
      check("rst_editing", int'(o_editing), 0);
      check("rst_load_hour", int'(o_load_hour), 0);
      check("rst_uart_err", int'(o_uart_err), 0);
      check("rst_ready", int'(o_uart_ready), 1);
      reset = 1'b0;
      @(negedge clk);

      // 13:45, hour ones wraps at 9; entry-cycle button ignored; live time ignored while editing
      add(2, 1, 0, 13, 45, 13, 45, 1, 0);
      add(2, 1, 0, 21, 7, 14, 45, 1, 0);
      add(2, 1, 0, 21, 7, 15, 45, 1, 0);
      add(2, 1, 0, 21, 7, 16, 45, 1, 0);
      add(2, 1, 0, 21, 7, 17, 45, 1, 0);
      add(2, 1, 0, 21, 7, 18, 45, 1, 0);
      add(2, 1, 0, 21, 7, 19, 45, 1, 0);
      add(2, 1, 0, 21, 7, 10, 45, 1, 0);
      add(0, 0, 0, 21, 7, 10, 45, 0, 1);
      add(0, 0, 0, 21, 7, 10, 45, 0, 0);
      // 19:00, hour tens with clamp and wrap
      add(1, 0, 0, 19, 0, 19, 0, 1, 0);
      add(1, 1, 0, 3, 3, 23, 0, 1, 0);
      add(1, 1, 0, 3, 3, 3, 0, 1, 0);
      add(1, 0, 1, 3, 3, 23, 0, 1, 0);
      add(1, 0, 1, 3, 3, 13, 0, 1, 0);
      add(1, 1, 0, 3, 3, 23, 0, 1, 0);
      add(2, 1, 0, 3, 3, 20, 0, 1, 0);
      add(2, 0, 1, 3, 3, 23, 0, 1, 0);
      add(0, 0, 0, 3, 3, 23, 0, 0, 1);
      add(0, 0, 0, 3, 3, 23, 0, 0, 0);
      // 00:59, minute digits; cursor 5..7 behaves as idle
      add(4, 0, 0, 0, 59, 0, 59, 1, 0);
      add(4, 1, 0, 9, 9, 0, 50, 1, 0);
      add(4, 0, 1, 9, 9, 0, 59, 1, 0);
      add(4, 0, 1, 9, 9, 0, 58, 1, 0);
      add(4, 1, 1, 9, 9, 0, 58, 1, 0);
      add(3, 0, 1, 9, 9, 0, 48, 1, 0);
      add(3, 1, 0, 9, 9, 0, 58, 1, 0);
      add(3, 1, 0, 9, 9, 0, 8, 1, 0);
      add(5, 0, 0, 12, 12, 0, 8, 0, 1);
      add(5, 0, 0, 12, 12, 0, 8, 0, 0);
      add(7, 0, 0, 12, 12, 0, 8, 0, 0);

      foreach (vt[i]) begin
         i_cursor   = 3'(vt[i].cur);
         i_btn_up   = 1'(vt[i].up);
         i_btn_down = 1'(vt[i].dn);
         i_hour     = 5'(vt[i].lh);
         i_min      = 6'(vt[i].lm);
         if (vt[i].commit != 0) push_load(vt[i].eh, vt[i].em);
         @(negedge clk);
         check("edit_hour", int'(o_edit_hour), vt[i].eh);
         check("edit_min", int'(o_edit_min), vt[i].em);
         check("editing", int'(o_editing), vt[i].ed);
      end
      i_cursor   = 3'd0;
      i_btn_up   = 1'b0;
      i_btn_down = 1'b0;
      @(negedge clk);

      // UART accept, ready low during LOAD, out-of-range drops, boundary 23:59
      i_uart_valid = 1'b1;
      i_uart_hour  = 5'd7;
      i_uart_min   = 6'd30;
      #1 check("uart_ready_idle", int'(o_uart_ready), 1);
      push_load(7, 30);
      @(negedge clk);
      i_uart_valid = 1'b0;
      #1 check("uart_ready_load", int'(o_uart_ready), 0);
      @(negedge clk);
      i_uart_valid = 1'b1;
      i_uart_hour  = 5'd24;
      i_uart_min   = 6'd0;
      #1 check("uart_ready_bad", int'(o_uart_ready), 1);
      n_err_exp++;
      @(negedge clk);
      i_uart_hour  = 5'd23;
      i_uart_min   = 6'd60;
      check("uart_err_pulse_h", int'(o_uart_err), 1);
      n_err_exp++;
      @(negedge clk);
      i_uart_valid = 1'b0;
      check("uart_err_pulse_m", int'(o_uart_err), 1);
      check("uart_err_keep_load", int'(o_load_hour), 7);
      @(negedge clk);
      check("uart_err_single", int'(o_uart_err), 0);
      i_uart_valid = 1'b1;
      i_uart_hour  = 5'd23;
      i_uart_min   = 6'd59;
      push_load(23, 59);
      @(negedge clk);
      i_uart_valid = 1'b0;
      @(negedge clk);

      // Tie: edit entry wins, UART waits through EDIT and LOAD
      i_hour       = 5'd8;
      i_min        = 6'd15;
      i_cursor     = 3'd1;
      i_uart_valid = 1'b1;
      i_uart_hour  = 5'd12;
      i_uart_min   = 6'd34;
      #1 check("tie_ready", int'(o_uart_ready), 0);
      @(negedge clk);
      check("tie_editing", int'(o_editing), 1);
      check("tie_ready_edit", int'(o_uart_ready), 0);
      i_cursor = 3'd0;
      push_load(8, 15);
      @(negedge clk);
      check("tie_ready_load", int'(o_uart_ready), 0);
      @(negedge clk);
      #1 check("tie_ready_after", int'(o_uart_ready), 1);
      push_load(12, 34);
      @(negedge clk);
      i_uart_valid = 1'b0;
      @(negedge clk);

      // Reset mid-edit discards shadow, no load
      i_hour   = 5'd11;
      i_min    = 6'd22;
      i_cursor = 3'd3;
      @(negedge clk);
      i_btn_up = 1'b1;
      @(negedge clk);
      i_btn_up = 1'b0;
      check("pre_rst_edit_min", int'(o_edit_min), 32);
      reset = 1'b1;
      @(negedge clk);
      i_cursor = 3'd0;
      check("mid_rst_edit_hour", int'(o_edit_hour), 0);
      check("mid_rst_edit_min", int'(o_edit_min), 0);
      check("mid_rst_editing", int'(o_editing), 0);
      check("mid_rst_load_hour", int'(o_load_hour), 0);
      check("mid_rst_load_min", int'(o_load_min), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_editing", int'(o_editing), 0);

      // Enter and leave without touching a digit
      i_hour   = 5'd5;
      i_min    = 6'd6;
      i_cursor = 3'd2;
      @(negedge clk);
      i_cursor = 3'd0;
`ifndef WATCH_EDIT_SKIP_UNCHANGED_EN
      push_load(5, 6);
`endif
      @(negedge clk);
      check("noedit_editing", int'(o_editing), 0);
      repeat (3) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      check("err_pulses", n_err_seen, n_err_exp);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
